// File: rtl/dot_mac_pkg.sv
// rtl/dot_mac_pkg.sv - shared state encoding and default sizes for the dot-product MAC
package dot_mac_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LANES = 2;
    localparam int DEF_ACC_W = 16;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/dot_mac_tree.sv
// rtl/dot_mac_tree.sv - combinational lane multiply-and-add tree with carry-out beyond ACC_W
module dot_mac_tree #(
    parameter int WIDTH = 8,
    parameter int LANES = 2,
    parameter int ACC_W = 16,
    localparam int SUM_W = 2*WIDTH + $clog2(LANES)
) (
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic [SUM_W-1:0]       sum,
    output logic                   carry
);

    // Full-precision sum of the per-lane unsigned products
    always_comb begin
        sum = '0;
        for (int k = 0; k < LANES; k++) begin
            sum = sum + (SUM_W'(a[k*WIDTH +: WIDTH]) * SUM_W'(b[k*WIDTH +: WIDTH]));
        end
    end

    // Any bit above the accumulator width means this beat alone overflows
    generate
        if (SUM_W > ACC_W) begin : g_carry
            assign carry = |sum[SUM_W-1:ACC_W];
        end else begin : g_no_carry
            assign carry = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/dot_mac.sv
// rtl/dot_mac.sv - two-stage dot-product accumulator; DOT_MAC_SAT_EN selects saturating accumulation
module dot_mac
    import dot_mac_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_sum,
    output logic                   out_ovf,
    output logic [CNT_W-1:0]       out_count
);

    localparam int SUM_W = 2*WIDTH + $clog2(LANES);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic               rdy_q, rdy_d;
    logic               s1_valid_q, s1_valid_d;
    logic               s1_last_q, s1_last_d;
    logic               s1_ovf_q, s1_ovf_d;
    logic [ACC_W-1:0]   s1_sum_q, s1_sum_d;
    logic               s2_last_q, s2_last_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;

    logic [SUM_W-1:0]   tree_sum;
    logic               tree_carry;
    logic [ACC_W-1:0]   beat_sum;
    logic [ACC_W:0]     add_w;
    logic               accept;

    dot_mac_tree #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .ACC_W (ACC_W)
    ) u_tree (
        .a     (in_a),
        .b     (in_b),
        .sum   (tree_sum),
        .carry (tree_carry)
    );

    // Fit the tree sum to the accumulator width; high bits are reported through tree_carry
    generate
        if (SUM_W > ACC_W) begin : g_trunc
            logic unused_hi;
            assign unused_hi = ^tree_sum[SUM_W-1:ACC_W];
            assign beat_sum  = tree_sum[ACC_W-1:0];
        end else if (SUM_W == ACC_W) begin : g_same
            assign beat_sum = tree_sum;
        end else begin : g_ext
            assign beat_sum = {{(ACC_W-SUM_W){1'b0}}, tree_sum};
        end
    endgenerate

    assign in_ready  = rdy_q && (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign add_w     = {1'b0, acc_q} + {1'b0, s1_sum_q};
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_count = cnt_q;

    // Next-state: pipeline advance, accumulate, FSM sequencing, then clr override
    always_comb begin
        state_d     = state_q;
        rdy_d       = 1'b1;
        s1_valid_d  = accept;
        s1_last_d   = in_last;
        s1_ovf_d    = tree_carry;
        s1_sum_d    = beat_sum;
        s2_last_d   = s1_valid_q && s1_last_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;

        if (s1_valid_q) begin
`ifdef DOT_MAC_SAT_EN
            acc_d = (s1_ovf_q || add_w[ACC_W]) ? ACC_MAX : add_w[ACC_W-1:0];
`else
            acc_d = add_w[ACC_W-1:0];
`endif
            ovf_d = ovf_q || s1_ovf_q || add_w[ACC_W];
        end

        if (accept && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            ACCUM: begin
                if (accept && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (s2_last_q) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    cnt_d       = '0;
                end
            end
            default: state_d = ACCUM;
        endcase

        if (clr) begin
            state_d     = ACCUM;
            s1_valid_d  = 1'b0;
            s2_last_d   = 1'b0;
            acc_d       = '0;
            ovf_d       = 1'b0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ACCUM;
            rdy_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_ovf_q    <= 1'b0;
            s1_sum_q    <= '0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_ovf_q    <= s1_ovf_d;
            s1_sum_q    <= s1_sum_d;
            s2_last_q   <= s2_last_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
